// File: rtl/strand_driver_mc_if.sv
// Pixel-strand driver bus: frame control, pixel RAM read port and strand pins.
// STRAND_BRIGHTNESS_EN adds the brightness input.
interface strand_driver_mc_if #(
  parameter int MEM_DATA_WIDTH     = 24,
  parameter int STRAND_PARAM_WIDTH = 16
);
  logic                          ws2811_mode;
  logic                          start_frame;
  logic [STRAND_PARAM_WIDTH-1:0] strand_length;
  logic [STRAND_PARAM_WIDTH-1:0] current_idx;
  logic [MEM_DATA_WIDTH-1:0]     mem_data;
  logic                          busy;
  logic                          done;
  logic                          strand_clk;
  logic                          strand_data;
`ifdef STRAND_BRIGHTNESS_EN
  logic [7:0]                    brightness;

  modport master (
    input  ws2811_mode, start_frame, strand_length, mem_data, brightness,
    output current_idx, busy, done, strand_clk, strand_data
  );
  modport slave (
    output ws2811_mode, start_frame, strand_length, mem_data, brightness,
    input  current_idx, busy, done, strand_clk, strand_data
  );
`else
  modport master (
    input  ws2811_mode, start_frame, strand_length, mem_data,
    output current_idx, busy, done, strand_clk, strand_data
  );
  modport slave (
    output ws2811_mode, start_frame, strand_length, mem_data,
    input  current_idx, busy, done, strand_clk, strand_data
  );
`endif
endinterface

// File: rtl/strand_driver_mc.sv
// WS2811 (NRZ) / WS2801 (clk+data) strand serializer fed by a sync pixel RAM; optional STRAND_BRIGHTNESS_EN scaling.
// First bit 2 cycles after acceptance, pixels back-to-back; no backpressure, start_frame ignored while busy.
module strand_driver_mc #(
  parameter int MEM_DATA_WIDTH     = 24,
  parameter int STRAND_PARAM_WIDTH = 16,
  parameter int T0H                = 20,
  parameter int T1H                = 40,
  parameter int TBIT               = 63,
  parameter int CLK_DIV            = 25,
  parameter int LATCH_CYCLES       = 2500
) (
  input  logic                clk,
  input  logic                rst_n,
  strand_driver_mc_if.master  bus
);
  localparam int W     = MEM_DATA_WIDTH;
  localparam int P2801 = 2 * CLK_DIV;
  localparam int CMAX0 = (TBIT > P2801) ? TBIT : P2801;
  localparam int CMAX  = (CMAX0 > LATCH_CYCLES) ? CMAX0 : LATCH_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int BW    = $clog2(W);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH, S_DONE} state_t;

  state_t                        state;
  logic                          mode_r;
  logic [STRAND_PARAM_WIDTH-1:0] len_r;
  logic [STRAND_PARAM_WIDTH-1:0] idx_r;
  logic [W-1:0]                  sh;
  logic [CW-1:0]                 per;
  logic [BW-1:0]                 bitn;
  logic                          last;
  logic                          busy_r, done_r, sclk_r, sdata_r;
  logic [W-1:0]                  load_word;
  logic [CW-1:0]                 per_last, thigh;
  logic                          idx_is_last;

`ifdef STRAND_BRIGHTNESS_EN
  always_comb begin
    logic [16:0] prod;
    load_word = '0;
    prod      = '0;
    for (int c = 0; c < W / 8; c++) begin
      prod = bus.mem_data[c*8 +: 8] * ({1'b0, bus.brightness} + 9'd1);
      load_word[c*8 +: 8] = prod[15:8];
    end
  end
`else
  assign load_word = bus.mem_data;
`endif

  assign per_last    = mode_r ? CW'(TBIT - 1) : CW'(P2801 - 1);
  assign thigh       = sh[W-1] ? CW'(T1H) : CW'(T0H);
  assign idx_is_last = (idx_r == len_r - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_r  <= 1'b0;
      len_r   <= '0;
      idx_r   <= '0;
      sh      <= '0;
      per     <= '0;
      bitn    <= '0;
      last    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start_frame) begin
            mode_r <= bus.ws2811_mode;
            len_r  <= bus.strand_length;
            idx_r  <= '0;
            busy_r <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (len_r == '0) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_DONE;
          end else begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          sh      <= load_word;
          per     <= '0;
          bitn    <= '0;
          last    <= idx_is_last;
          if (!idx_is_last) idx_r <= idx_r + 1'b1;
          sclk_r  <= 1'b0;
          sdata_r <= mode_r ? 1'b1 : load_word[W-1];
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (per == per_last) begin
            per    <= '0;
            sclk_r <= 1'b0;
            if (bitn == BW'(W - 1)) begin
              if (last) begin
                sdata_r <= 1'b0;
                state   <= S_LATCH;
              end else begin
                // Next pixel was prefetched during this one; load it with no gap.
                sh      <= load_word;
                bitn    <= '0;
                last    <= idx_is_last;
                if (!idx_is_last) idx_r <= idx_r + 1'b1;
                sdata_r <= mode_r ? 1'b1 : load_word[W-1];
              end
            end else begin
              sh      <= sh << 1;
              bitn    <= bitn + 1'b1;
              sdata_r <= mode_r ? 1'b1 : sh[W-2];
            end
          end else begin
            per <= per + 1'b1;
            if (mode_r) sdata_r <= ((per + 1'b1) < thigh);
            else        sclk_r  <= ((per + 1'b1) >= CW'(CLK_DIV));
          end
        end
        S_LATCH: begin
          if (per == CW'(LATCH_CYCLES - 1)) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            idx_r  <= '0;
            state  <= S_DONE;
          end else begin
            per <= per + 1'b1;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.current_idx = idx_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.strand_clk  = sclk_r;
  assign bus.strand_data = sdata_r;
endmodule

// File: tb/tb_strand_driver_mc.sv
// Scoreboard bench: stimulus queues expected bits and done cycles; a negedge monitor decodes the strand and pops.
module tb_strand_driver_mc;
  localparam int T0H = 3, T1H = 6, TBIT = 10, CLK_DIV = 2, LATCH = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  logic [23:0] mem [0:7];
  bit          exp_bits[$];
  int          exp_done[$];
  logic        cur_mode = 1'b0;
  int          cur_len = 0;

  strand_driver_mc_if #(.MEM_DATA_WIDTH(24), .STRAND_PARAM_WIDTH(16)) bus();

  strand_driver_mc #(
    .MEM_DATA_WIDTH(24), .STRAND_PARAM_WIDTH(16), .T0H(T0H), .T1H(T1H),
    .TBIT(TBIT), .CLK_DIV(CLK_DIV), .LATCH_CYCLES(LATCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_data <= mem[bus.current_idx[2:0]];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: decodes pulse widths (WS2811) or clk-rise samples (WS2801).
  logic p_clk = 1'b0, p_dat = 1'b0;
  int   hi_len = 0;
  int   last_rise = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_clk = 1'b0; p_dat = 1'b0; hi_len = 0; last_rise = -1;
    end else begin
      if (!bus.busy) last_rise = -1;
      if (bus.done) begin
        chk("busy_low_at_done", bus.busy, 0);
        chk("idx_zero_at_done", bus.current_idx, 0);
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
      if (cur_mode) begin
        if (bus.strand_data && !p_dat) begin
          chk("ws2811_clk_held_low", bus.strand_clk, 0);
          chk("idx_within_length", bus.current_idx <= cur_len, 1);
          if (last_rise >= 0) chk("ws2811_bit_period", cyc - last_rise, TBIT);
          last_rise = cyc;
          hi_len = 0;
        end
        if (bus.strand_data) hi_len++;
        else if (p_dat) begin
          int got;
          got = (hi_len == T1H) ? 1 : (hi_len == T0H) ? 0 : -1;
          if (exp_bits.size() == 0) chk("unexpected_ws2811_bit", 1, 0);
          else chk("ws2811_bit", got, exp_bits.pop_front());
        end
      end else if (bus.strand_clk && !p_clk) begin
        if (last_rise >= 0) chk("ws2801_clk_period", cyc - last_rise, 2 * CLK_DIV);
        last_rise = cyc;
        chk("idx_within_length", bus.current_idx <= cur_len, 1);
        if (exp_bits.size() == 0) chk("unexpected_ws2801_bit", 1, 0);
        else chk("ws2801_bit", bus.strand_data, exp_bits.pop_front());
      end
      p_clk = bus.strand_clk;
      p_dat = bus.strand_data;
    end
  end

  task automatic accept(input logic mode, input int len, input bit ovr,
                        input logic [23:0] ovr_word, output int a);
    logic [23:0] w;
    @(negedge clk);
    cur_mode = mode;
    cur_len  = len;
    bus.ws2811_mode   = mode;
    bus.strand_length = len[15:0];
    for (int p = 0; p < len; p++) begin
      w = ovr ? ovr_word : mem[p];
      for (int b = 23; b >= 0; b--) exp_bits.push_back(w[b]);
    end
    bus.start_frame = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    bus.start_frame = 1'b0;
    // Scramble inputs after acceptance; the frame must use the latched values.
    bus.ws2811_mode   = ~mode;
    bus.strand_length = 16'hFFFF;
    if (len == 0) exp_done.push_back(a + 1);
    else exp_done.push_back(a + 2 + len * 24 * (mode ? TBIT : 2 * CLK_DIV) + LATCH);
  endtask

  task automatic run_frame(input logic mode, input int len, input bit repulse,
                           input bit ovr, input logic [23:0] ovr_word);
    int a;
    accept(mode, len, ovr, ovr_word, a);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start_frame = (repulse && i == 50);
      if (exp_done.size() == 0) break;
    end
    bus.start_frame = 1'b0;
    chk("frame_done_timeout", exp_done.size(), 0);
    chk("bits_left_over", exp_bits.size(), 0);
    repeat (3) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_idx", bus.current_idx, 0);
    exp_done.delete();
    exp_bits.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    bus.ws2811_mode   = 1'b0;
    bus.start_frame   = 1'b0;
    bus.strand_length = '0;
`ifdef STRAND_BRIGHTNESS_EN
    bus.brightness    = 8'd255;
`endif
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_idx", bus.current_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_strand_clk", bus.strand_clk, 0);
    chk("rst_strand_data", bus.strand_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // WS2811, two pixels, with a stray start_frame mid-frame.
    mem[0] = 24'hFF0055; mem[1] = 24'h00AA81;
    run_frame(1'b1, 2, 1'b1, 1'b0, 24'h0);
    // WS2801, single pixel.
    mem[0] = 24'hA50000;
    run_frame(1'b0, 1, 1'b0, 1'b0, 24'h0);
    // WS2801, three pixels back-to-back.
    mem[0] = 24'h3C0F81; mem[1] = 24'hFFFFFF; mem[2] = 24'h800001;
    run_frame(1'b0, 3, 1'b0, 1'b0, 24'h0);
    // Zero-length frames in both modes.
    run_frame(1'b1, 0, 1'b0, 1'b0, 24'h0);
    run_frame(1'b0, 0, 1'b0, 1'b0, 24'h0);

    // Reset during bit 5 of pixel 0 (that bit is a 1, so data is high).
    mem[0] = 24'hFF0055; mem[1] = 24'h00AA81;
    accept(1'b1, 2, 1'b0, 24'h0, a);
    for (int i = 0; i < 200 && cyc < a + 2 + 5 * TBIT + 3; i++) @(negedge clk);
    chk("pre_reset_data_high", bus.strand_data, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", bus.strand_data, 0);
    chk("async_rst_clk", bus.strand_clk, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_idx", bus.current_idx, 0);
    exp_bits.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_resume_busy", bus.busy, 0);
    chk("no_resume_data", bus.strand_data, 0);
    run_frame(1'b1, 2, 1'b0, 1'b0, 24'h0);

`ifdef STRAND_BRIGHTNESS_EN
    bus.brightness = 8'd127;
    mem[0] = 24'hFF0080;
    run_frame(1'b0, 1, 1'b0, 1'b1, 24'h7F0040);
    bus.brightness = 8'd255;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
